dmem_initiator: RTL and testbench

- Initiator side of the core data-memory interface (req/gnt/rvalid, byte enables, word-addressed responder).
- Converts simple host commands (address, size, sign, right-aligned data) into bus transactions: byte-lane enables, lane-replicated write data, and extracted/extended read data.
- Used by the test bench and DMA-style helpers to drive data_memory-class responders without a RI5CY LSU.
- One outstanding transaction at a time; registered bus outputs.

---
 rtl/dmem_initiator.sv | 195 +++++++++++++++++++
 tb/tb_dmem_initiator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_initiator.sv
// Data-memory bus initiator: turns host load/store commands into req/gnt/rvalid transactions.
// Optional macro DMEM_TIMEOUT_EN aborts a transaction stuck in REQ/RSP after TIMEOUT_CYCLES.
module dmem_initiator #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [1:0]  cmd_size,
   input  logic        cmd_signed,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        data_req,
   output logic [31:0] data_addr,
   output logic [3:0]  data_be,
   output logic        data_write,
   output logic [31:0] data_wdata,
   input  logic        data_gnt,
   input  logic        data_rvalid,
   input  logic [31:0] data_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, RSP, ERR} state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << CNT_W) - 1) begin : g_bad_cnt_w
      $error("CNT_W too narrow for TIMEOUT_CYCLES");
   end

   state_t      state, state_next;
   logic [1:0]  lat_off, lat_size;
   logic        lat_signed, lat_write;
   logic        legal, accept, timeout_hit;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata, load_data;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   logic        req_next, write_next, rsp_valid_next, rsp_err_next;
   logic [31:0] addr_next, wdata_next, rsp_rdata_next;
   logic [3:0]  be_next;

   assign cmd_ready = (state == IDLE);
   assign legal     = (cmd_size == 2'b00) ||
                      (cmd_size == 2'b01 && !cmd_addr[0]) ||
                      (cmd_size == 2'b10 && cmd_addr[1:0] == 2'b00);
   assign accept    = (state == IDLE) && cmd_valid && legal;

`ifdef DMEM_TIMEOUT_EN
   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         wait_cnt <= '0;
      else if (accept)
         wait_cnt <= '0;
      else if (state == REQ || state == RSP)
         wait_cnt <= wait_cnt + 1'b1;
   end

   assign timeout_hit = (state == REQ || state == RSP) &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // Lane steering for stores and lane extraction/extension for loads
   always_comb begin
      lane_be    = 4'b1111;
      lane_wdata = cmd_wdata;
      case (cmd_size)
         2'b00: begin
            lane_be    = 4'b0001 << cmd_addr[1:0];
            lane_wdata = {4{cmd_wdata[7:0]}};
         end
         2'b01: begin
            lane_be    = 4'b0011 << cmd_addr[1:0];
            lane_wdata = {2{cmd_wdata[15:0]}};
         end
         default: ;
      endcase
      rd_byte = data_rdata[{lat_off, 3'b000} +: 8];
      rd_half = data_rdata[{lat_off[1], 4'b0000} +: 16];
      case (lat_size)
         2'b00:   load_data = {{24{lat_signed & rd_byte[7]}}, rd_byte};
         2'b01:   load_data = {{16{lat_signed & rd_half[15]}}, rd_half};
         default: load_data = data_rdata;
      endcase
   end

   always_comb begin
      state_next     = state;
      req_next       = data_req;
      addr_next      = data_addr;
      be_next        = data_be;
      write_next     = data_write;
      wdata_next     = data_wdata;
      rsp_valid_next = 1'b0;
      rsp_err_next   = 1'b0;
      rsp_rdata_next = rsp_rdata;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               if (legal) begin
                  state_next = REQ;
                  req_next   = 1'b1;
                  addr_next  = {cmd_addr[31:2], 2'b00};
                  be_next    = lane_be;
                  write_next = cmd_write;
                  wdata_next = lane_wdata;
               end else begin
                  state_next = ERR;
               end
            end
         end
         REQ: begin
            if (data_gnt) begin
               state_next = RSP;
               req_next   = 1'b0;
            end else if (timeout_hit) begin
               state_next     = IDLE;
               req_next       = 1'b0;
               rsp_valid_next = 1'b1;
               rsp_err_next   = 1'b1;
               rsp_rdata_next = '0;
            end
         end
         RSP: begin
            if (data_rvalid) begin
               state_next     = IDLE;
               rsp_valid_next = 1'b1;
               rsp_rdata_next = lat_write ? 32'h0 : load_data;
            end else if (timeout_hit) begin
               state_next     = IDLE;
               rsp_valid_next = 1'b1;
               rsp_err_next   = 1'b1;
               rsp_rdata_next = '0;
            end
         end
         ERR: begin
            state_next     = IDLE;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            rsp_rdata_next = '0;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Bus and response outputs are registered; command attributes kept for load extraction
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         data_req   <= 1'b0;
         data_addr  <= '0;
         data_be    <= '0;
         data_write <= 1'b0;
         data_wdata <= '0;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= '0;
         lat_off    <= '0;
         lat_size   <= '0;
         lat_signed <= 1'b0;
         lat_write  <= 1'b0;
      end else begin
         data_req   <= req_next;
         data_addr  <= addr_next;
         data_be    <= be_next;
         data_write <= write_next;
         data_wdata <= wdata_next;
         rsp_valid  <= rsp_valid_next;
         rsp_err    <= rsp_err_next;
         rsp_rdata  <= rsp_rdata_next;
         if (accept) begin
            lat_off    <= cmd_addr[1:0];
            lat_size   <= cmd_size;
            lat_signed <= cmd_signed;
            lat_write  <= cmd_write;
         end
      end
   end

endmodule

// File: tb/tb_dmem_initiator.sv
// Self-checking bench for dmem_initiator: vector table against a stallable word-addressed responder.
module tb_dmem_initiator;

`ifdef DMEM_TIMEOUT_EN
   localparam int TB_TIMEOUT = 8;
`else
   localparam int TB_TIMEOUT = 255;
`endif

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        cmd_valid, cmd_ready, cmd_write, cmd_signed;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [1:0]  cmd_size;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        data_req, data_write, data_gnt, data_rvalid;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_be;

   always #5 HCLK = ~HCLK;

   dmem_initiator #(.TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_W(8)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_signed(cmd_signed),
      .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .data_req(data_req), .data_addr(data_addr),
      .data_be(data_be), .data_write(data_write), .data_wdata(data_wdata),
      .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata)
   );

   // Responder: grants after stall_cycles of request, answers one cycle after grant
   logic [31:0] mem [0:15] = '{default: 32'h0};
   int          stall_cycles = 0;
   int          req_cycles = 0;
   logic        rvalid_q = 1'b0;
   logic [31:0] rdata_q = 32'h0;
   logic        stray_rvalid = 1'b0;

   assign data_gnt    = data_req && (req_cycles >= stall_cycles);
   assign data_rvalid = rvalid_q | stray_rvalid;
   assign data_rdata  = rdata_q;

   always @(posedge HCLK) begin
      rvalid_q <= 1'b0;
      if (data_req && data_gnt) begin
         rvalid_q   <= 1'b1;
         req_cycles <= 0;
         rdata_q    <= data_write ? 32'h0 : mem[data_addr[5:2]];
         if (data_write)
            for (int i = 0; i < 4; i++)
               if (data_be[i]) mem[data_addr[5:2]][8*i +: 8] <= data_wdata[8*i +: 8];
      end else if (data_req) begin
         req_cycles <= req_cycles + 1;
      end else begin
         req_cycles <= 0;
      end
   end

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   vec_t vecs [17];
   exp_t sb [$];
   int   applied = 0;
   int   miscompares = 0;

   function automatic vec_t mk(logic w, logic [31:0] a, logic [1:0] s, logic sg,
                               logic [31:0] wd, logic e, logic [31:0] ea,
                               logic [3:0] eb, logic [31:0] ew, logic [31:0] er);
      vec_t v;
      v.write = w; v.addr = a; v.size = s; v.sgn = sg; v.wdata = wd; v.err = e;
      v.exp_addr = ea; v.exp_be = eb; v.exp_wdata = ew; v.exp_rdata = er;
      return v;
   endfunction

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // Pops the oldest expected response and checks it against the DUT response
   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         compare("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         compare("rsp_rdata", rsp_rdata, e.rdata);
         compare("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int stall, input int exp_lat,
                                input logic exp_req, input logic exp_err);
      int   cyc;
      bit   got, seen;
      int   unstable;
      exp_t e;
      stall_cycles = stall;
      cyc = 0;
      @(negedge HCLK);
      while (!cmd_ready && cyc < 50) begin
         @(negedge HCLK);
         cyc++;
      end
      compare("cmd_ready_wait", {31'h0, cmd_ready}, 32'd1);
      cmd_valid  = 1'b1;
      cmd_write  = v.write;
      cmd_addr   = v.addr;
      cmd_size   = v.size;
      cmd_signed = v.sgn;
      cmd_wdata  = v.wdata;
      e.rdata = exp_err ? 32'h0 : v.exp_rdata;
      e.err   = exp_err;
      sb.push_back(e);
      @(posedge HCLK);
      #1 cmd_valid = 1'b0;
      cyc = 0; got = 0; seen = 0; unstable = 0;
      while (!got && cyc < 60) begin
         @(negedge HCLK);
         cyc++;
         if (data_req) begin
            if (!seen) begin
               seen = 1;
               compare("data_addr", data_addr, v.exp_addr);
               compare("data_be", {28'h0, data_be}, {28'h0, v.exp_be});
               compare("data_write", {31'h0, data_write}, {31'h0, v.write});
               compare("data_wdata", data_wdata, v.exp_wdata);
            end else if (data_addr !== v.exp_addr || data_be !== v.exp_be ||
                         data_wdata !== v.exp_wdata || data_write !== v.write) begin
               unstable++;
            end
         end
         if (rsp_valid) begin
            got = 1;
            compare("latency", cyc, exp_lat);
            compare("cmd_ready_at_rsp", {31'h0, cmd_ready}, 32'd1);
            checkOutput();
         end
      end
      if (!got) begin
         compare("rsp_timeout", 32'd0, 32'd1);
         void'(sb.pop_back());
      end
      compare("req_issued", {31'h0, seen}, {31'h0, exp_req});
      if (stall > 0) compare("bus_stable", unstable, 0);
      @(negedge HCLK);
      compare("rsp_pulse", {31'h0, rsp_valid}, 32'd0);
   endtask

   initial begin
      int noresp;
      vecs[0]  = mk(1, 32'h00100000, 2'b10, 0, 32'hDEADBEEF, 0, 32'h00100000, 4'hF, 32'hDEADBEEF, 32'h0);
      vecs[1]  = mk(0, 32'h00100003, 2'b00, 1, 32'h0, 0, 32'h00100000, 4'h8, 32'h0, 32'hFFFFFFDE);
      vecs[2]  = mk(0, 32'h00100002, 2'b01, 0, 32'h0, 0, 32'h00100000, 4'hC, 32'h0, 32'h0000DEAD);
      vecs[3]  = mk(1, 32'h00100001, 2'b00, 0, 32'h0000005A, 0, 32'h00100000, 4'h2, 32'h5A5A5A5A, 32'h0);
      vecs[4]  = mk(0, 32'h00100000, 2'b10, 0, 32'h0, 0, 32'h00100000, 4'hF, 32'h0, 32'hDEAD5AEF);
      vecs[5]  = mk(0, 32'h00100001, 2'b10, 0, 32'h0, 1, 32'h0, 4'h0, 32'h0, 32'h0);
      vecs[6]  = mk(0, 32'h00100000, 2'b11, 0, 32'h0, 1, 32'h0, 4'h0, 32'h0, 32'h0);
      vecs[7]  = mk(0, 32'h00100001, 2'b01, 0, 32'h0, 1, 32'h0, 4'h0, 32'h0, 32'h0);
      vecs[8]  = mk(0, 32'h00100002, 2'b01, 1, 32'h0, 0, 32'h00100000, 4'hC, 32'h0, 32'hFFFFDEAD);
      vecs[9]  = mk(0, 32'h00100001, 2'b00, 1, 32'h0, 0, 32'h00100000, 4'h2, 32'h0, 32'h0000005A);
      vecs[10] = mk(1, 32'h00100006, 2'b01, 0, 32'hABCD1234, 0, 32'h00100004, 4'hC, 32'h12341234, 32'h0);
      vecs[11] = mk(0, 32'h00100007, 2'b00, 1, 32'h0, 0, 32'h00100004, 4'h8, 32'h0, 32'h00000012);
      vecs[12] = mk(0, 32'h00100004, 2'b10, 0, 32'h0, 0, 32'h00100004, 4'hF, 32'h0, 32'h12340000);
      vecs[13] = mk(1, 32'h00100008, 2'b00, 0, 32'hFFFFFF97, 0, 32'h00100008, 4'h1, 32'h97979797, 32'h0);
      vecs[14] = mk(0, 32'h00100008, 2'b00, 1, 32'h0, 0, 32'h00100008, 4'h1, 32'h0, 32'hFFFFFF97);
      vecs[15] = mk(0, 32'h00100008, 2'b01, 1, 32'h0, 0, 32'h00100008, 4'h3, 32'h0, 32'h00000097);
      vecs[16] = mk(1, 32'h00100002, 2'b10, 0, 32'hDEADBEEF, 1, 32'h0, 4'h0, 32'h0, 32'h0);

      HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_size = '0; cmd_signed = 1'b0; cmd_wdata = '0;
      repeat (2) @(negedge HCLK);
      compare("rst_data_req", {31'h0, data_req}, 32'd0);
      compare("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      compare("rst_data_be", {28'h0, data_be}, 32'd0);
      compare("rst_data_addr", data_addr, 32'd0);
      compare("rst_rsp_rdata", rsp_rdata, 32'd0);
      HRESETn = 1'b1;
      @(negedge HCLK);
      compare("rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);

      for (int i = 0; i < 17; i++)
         applyStimulus(vecs[i], 0, vecs[i].err ? 2 : 3, !vecs[i].err, vecs[i].err);

      // Grant withheld for four cycles
      applyStimulus(vecs[4], 4, 7, 1'b1, 1'b0);

      // Stray rvalid while idle must not produce a response
      @(negedge HCLK);
      stray_rvalid = 1'b1;
      noresp = 0;
      @(negedge HCLK);
      stray_rvalid = 1'b0;
      if (rsp_valid) noresp++;
      @(negedge HCLK);
      if (rsp_valid) noresp++;
      compare("stray_rvalid_ignored", noresp, 0);

      // Reset while waiting for the response
      stall_cycles = 0;
      @(negedge HCLK);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h00100000;
      cmd_size = 2'b10; cmd_signed = 1'b0; cmd_wdata = 32'h0;
      @(posedge HCLK);
      #1 cmd_valid = 1'b0;
      @(negedge HCLK);
      compare("rstmid_req_before", {31'h0, data_req}, 32'd1);
      @(posedge HCLK);
      #1 HRESETn = 1'b0;
      #1;
      compare("rstmid_data_req", {31'h0, data_req}, 32'd0);
      compare("rstmid_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      noresp = 0;
      repeat (3) begin
         @(negedge HCLK);
         if (rsp_valid) noresp++;
      end
      compare("rstmid_no_response", noresp, 0);
      applyStimulus(vecs[12], 0, 3, 1'b1, 1'b0);

`ifdef DMEM_TIMEOUT_EN
      // Never granted: abort after TB_TIMEOUT cycles, then a normal command
      applyStimulus(vecs[12], 100000, TB_TIMEOUT + 1, 1'b1, 1'b1);
      compare("timeout_cmd_ready", {31'h0, cmd_ready}, 32'd1);
      applyStimulus(vecs[4], 0, 3, 1'b1, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
